clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 16, number of idle tick_1hz pulses in a set mode before automatic return to RUN.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 tick_1hz  in  1  one-clk-wide pulse, once per second.
REQ-005 btn_mode  in  1  debounced one-clk pulse; advances the set-mode sequence.
REQ-006 btn_inc  in  1  debounced one-clk pulse; increments the field being set.
REQ-007 hr_q  in  5  current hours counter value, 0-23.
REQ-008 min_q  in  6  current minutes counter value, 0-59.
REQ-009 sec_q  in  6  current seconds counter value, 0-59.
REQ-010 sec_en, min_en, hr_en  out  1 each  count enables to the seconds/minutes/hours counters.
REQ-011 sec_load, min_load, hr_load  out  1 each  load strobes to the counters.
REQ-012 min_data  out  6; hr_data  out  5  load values (sec load value is always 0 and has no port).
REQ-013 mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN.
REQ-014 blink  out  1  display blink phase for the field being set.

Function
REQ-015 All outputs SHALL be registered; each response appears exactly one clk after the triggering input cycle.
REQ-016 FSM states SHALL be RUN, SET_HR, SET_MIN; btn_mode transitions RUN->SET_HR->SET_MIN->RUN.
REQ-017 In RUN, tick_1hz SHALL pulse sec_en; additionally min_en if sec_q==59; additionally hr_en if sec_q==59 and min_q==59.
REQ-018 In SET_HR and SET_MIN, sec_en, min_en and hr_en SHALL stay 0 (time frozen); ticks are not accumulated.
REQ-019 In SET_HR, btn_inc SHALL pulse hr_load with hr_data = (hr_q==23) ? 0 : hr_q+1.
REQ-020 In SET_MIN, btn_inc SHALL pulse min_load with min_data = (min_q==59) ? 0 : min_q+1; hours unaffected.
REQ-021 On any transition SET_MIN->RUN (button or timeout), sec_load SHALL pulse once, clearing seconds.
REQ-022 btn_inc in RUN SHALL be ignored.
REQ-023 btn_mode and btn_inc in the same cycle: mode transition taken, inc ignored.
REQ-024 An idle counter SHALL reset to 0 on entry to a set mode and on any button pulse, increment on each tick_1hz, and when it reaches TIMEOUT_TICKS force a return to RUN (via REQ-021 path from SET_MIN; directly from SET_HR without sec_load).
REQ-025 Button and tick in the same cycle in a set mode: button processed, idle counter cleared, blink still toggles.
REQ-026 blink SHALL toggle on each tick_1hz in set modes, be forced to 1 on every btn_inc in set modes, and be 0 in RUN.
REQ-027 All load/enable outputs SHALL be single-cycle pulses; at most one load strobe asserted per cycle.

Reset
REQ-028 While rst is high: state RUN, mode=00, all enables/loads 0, hr_data=0, min_data=0, blink=0, idle counter 0.
REQ-029 Reset asserted mid-set-mode SHALL abandon the set without issuing any load strobe.
REQ-030 After rst deasserts, the first tick_1hz SHALL be handled normally.

Structure
REQ-031 Shared package SHALL hold the state/mode encoding, HR_MAX=23, MIN_MAX=59, SEC_MAX=59.
REQ-032 The idle timeout counter SHALL be a sub-module clkset_timeout (inputs clk, rst, clr, tick; output expired).

Verification
REQ-033 RUN, sec_q=59, min_q=59, hr_q=23, tick -> next cycle sec_en=min_en=hr_en=1, no loads.
REQ-034 btn_mode once, hr_q=23, btn_inc -> mode=01, hr_load=1 with hr_data=0; sec_en stays 0 on following ticks.
REQ-035 btn_mode twice, min_q=59, btn_inc -> min_load=1, min_data=0; btn_mode -> mode=00 and sec_load=1 one cycle.
REQ-036 SET_MIN, 16 ticks with no buttons -> return to RUN with sec_load pulse; SET_HR, 16 idle ticks -> RUN, no sec_load.
REQ-037 SET_HR, btn_mode+btn_inc same cycle -> mode=10, no hr_load.
REQ-038 rst pulsed in SET_MIN after a btn_inc -> mode=00, all strobes 0, no sec_load.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: shared state encoding and time-field limits
package clock_set_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;
endpackage

// File: rtl/clock_set_ctrl_timeout.sv
// clkset_timeout: counts idle ticks and flags the tick that reaches the limit
module clkset_timeout #(
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_TICKS + 1);
  logic [W-1:0] cnt;
  assign expired = tick && !clr && cnt == W'(TIMEOUT_TICKS - 1);
  // clear has priority over counting so a button in a tick cycle restarts the wait
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : tick ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set-mode controller driving the clock counters
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] hr_q,
  input  logic [5:0] min_q,
  input  logic [5:0] sec_q,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       sec_load,
  output logic       min_load,
  output logic       hr_load,
  output logic [5:0] min_data,
  output logic [4:0] hr_data,
  output logic [1:0] mode,
  output logic       blink
);
  state_t state, nxt;
  logic sec_en_d, min_en_d, hr_en_d, sec_load_d, min_load_d, hr_load_d, blink_d;
  logic [5:0] min_data_d;
  logic [4:0] hr_data_d;
  logic set, inc_ok, expired;
  assign set    = state != RUN;
  assign inc_ok = set && btn_inc && !btn_mode;
  assign mode   = state;
  clkset_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!set || btn_mode || btn_inc),
    .tick    (tick_1hz),
    .expired (expired)
  );
  // next state and next registered outputs, all decided from the current cycle's inputs
  always_comb begin
    nxt        = btn_mode ? (state == RUN ? SET_HR : state == SET_HR ? SET_MIN : RUN)
               : (set && expired) ? RUN : state;
    sec_en_d   = state == RUN && tick_1hz;
    min_en_d   = sec_en_d && sec_q == SEC_MAX;
    hr_en_d    = min_en_d && min_q == MIN_MAX;
    hr_load_d  = inc_ok && state == SET_HR;
    min_load_d = inc_ok && state == SET_MIN;
    hr_data_d  = !hr_load_d ? '0 : hr_q == HR_MAX ? '0 : hr_q + 5'd1;
    min_data_d = !min_load_d ? '0 : min_q == MIN_MAX ? '0 : min_q + 6'd1;
    sec_load_d = state == SET_MIN && nxt == RUN;
    blink_d    = nxt == RUN ? 1'b0 : inc_ok ? 1'b1 : (set && tick_1hz) ? !blink : blink;
  end
  // state and output registers; reset abandons any set in progress without strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RUN;
      sec_en   <= 1'b0;
      min_en   <= 1'b0;
      hr_en    <= 1'b0;
      sec_load <= 1'b0;
      min_load <= 1'b0;
      hr_load  <= 1'b0;
      min_data <= '0;
      hr_data  <= '0;
      blink    <= 1'b0;
    end else begin
      state    <= nxt;
      sec_en   <= sec_en_d;
      min_en   <= min_en_d;
      hr_en    <= hr_en_d;
      sec_load <= sec_load_d;
      min_load <= min_load_d;
      hr_load  <= hr_load_d;
      min_data <= min_data_d;
      hr_data  <= hr_data_d;
      blink    <= blink_d;
    end
endmodule
